// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus glue.
//   ID_*      : owner tags stored per outstanding transaction
//   SIZE_*    : encodings of the 2-bit sram-like size field
//   *_BITS    : fixed widths of sram-like request fields
package sram_like_pkg;

    // Which master issued a transaction.
    typedef logic owner_id_t;

    localparam owner_id_t ID_INST = 1'b0;
    localparam owner_id_t ID_DATA = 1'b1;

    localparam int unsigned SIZE_BITS = 2;
    localparam int unsigned ID_BITS   = 1;

    localparam logic [SIZE_BITS-1:0] SIZE_B = 2'd0;
    localparam logic [SIZE_BITS-1:0] SIZE_H = 2'd1;
    localparam logic [SIZE_BITS-1:0] SIZE_W = 2'd2;

    // Number of byte strobes for a given data width.
    function automatic int unsigned strb_bits(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// Synchronous FIFO of owner tags, one entry per accepted-but-unanswered
// sram-like transaction. Entries are pushed in acceptance order and popped
// in response order, so the head always names the owner of the next response.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pointers/count)
//   push      : enqueue push_id (ignored while full)
//   push_id   : owner tag to enqueue
//   pop       : dequeue head (ignored while empty)
//   head      : owner tag at the front
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of valid entries, 0..DEPTH
module owner_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 4  // power of 2, 2..16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  owner_id_t                push_id,
    input  logic                     pop,
    output owner_id_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    owner_id_t          slots_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic push_en;
    logic pop_en;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        push_en = push & ~full;
        pop_en  = pop & ~empty;
        head    = slots_q[rd_ptr_q];
        count   = count_q;
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            slots_q[wr_ptr_q] <= push_id;
        end
    end

    // DEPTH is a power of 2, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data sram-like request streams onto a
// single sram-like memory port and routes each in-order memory response back
// to the master that issued it.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   inst_* (in)       : instruction master request (req/wr/size/addr/wstrb/wdata)
//   inst_addr_ok      : instruction request accepted this cycle
//   inst_data_ok      : instruction response pulse, inst_rdata valid with it
//   data_* (in)       : data master request, same shape as inst_*
//   data_addr_ok/data_data_ok/data_rdata : data master handshake/response
//   mem_* (out)       : memory-side request
//   mem_addr_ok       : memory accepted the presented request
//   mem_data_ok       : memory response pulse, in acceptance order
//   mem_rdata         : memory read data
//   err               : sticky: a response arrived with nothing outstanding
//
// Data has fixed priority, but once a request has been presented and not yet
// accepted the grant is locked so the memory never sees it withdrawn/swapped.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 inst_req,
    input  logic                 inst_wr,
    input  logic [1:0]           inst_size,
    input  logic [AW-1:0]        inst_addr,
    input  logic [DW/8-1:0]      inst_wstrb,
    input  logic [DW-1:0]        inst_wdata,
    output logic                 inst_addr_ok,
    output logic                 inst_data_ok,
    output logic [DW-1:0]        inst_rdata,

    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [1:0]           data_size,
    input  logic [AW-1:0]        data_addr,
    input  logic [DW/8-1:0]      data_wstrb,
    input  logic [DW-1:0]        data_wdata,
    output logic                 data_addr_ok,
    output logic                 data_data_ok,
    output logic [DW-1:0]        data_rdata,

    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [1:0]           mem_size,
    output logic [AW-1:0]        mem_addr,
    output logic [DW/8-1:0]      mem_wstrb,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_addr_ok,
    input  logic                 mem_data_ok,
    input  logic [DW-1:0]        mem_rdata,

    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

    // Grant lock state
    logic       lock_valid_q, lock_valid_d;
    owner_id_t  lock_id_q, lock_id_d;

    // Sticky protocol error
    logic       err_q, err_d;

    owner_id_t  sel;
    logic       handshake;
    logic       resp_pop;
    logic       spurious;

    owner_id_t  fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    always_comb begin
        sel = ID_INST;
        if (lock_valid_q) begin
            sel = lock_id_q;
        end else if (data_req) begin
            sel = ID_DATA;
        end
    end

    always_comb begin
        mem_req   = ~rst & ~fifo_full & (lock_valid_q | data_req | inst_req);
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
        if (sel == ID_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end
    end

    always_comb begin
        handshake    = mem_req & mem_addr_ok;
        inst_addr_ok = handshake & (sel == ID_INST);
        data_addr_ok = handshake & (sel == ID_DATA);
    end

    // ------------------------------------------------------------------
    // Grant lock: freeze sel while a presented request waits for addr_ok
    // ------------------------------------------------------------------
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (handshake) begin
            lock_valid_d = 1'b0;
        end else if (mem_req && !lock_valid_q) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_INST;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    // Gated by rst so no stale owner is answered while being cleared.
    always_comb begin
        resp_pop     = mem_data_ok & ~fifo_empty & ~rst;
        spurious     = mem_data_ok & fifo_empty & ~rst;
        inst_data_ok = resp_pop & (fifo_head == ID_INST);
        data_data_ok = resp_pop & (fifo_head == ID_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    owner_fifo #(
        .DEPTH   (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (sel),
        .pop     (resp_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q | spurious;
        err   = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // A handshake always clears the lock, and only a handshake raises the
    // count, so the FIFO can never fill while a request is locked.
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CNT_W'(OUTSTANDING));
    a_no_full_locked: assert property (@(posedge clk) disable iff (rst)
        !(lock_valid_q && fifo_full));

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Sits directly downstream of the CPU core, between it and the memory system.
- Merges the core's instruction and data sram-like request streams onto one sram-like memory port.
- Tracks which master owns each outstanding transaction, so each in-order memory response is routed back to the master that issued it.
- Prerequisite for moving the core off ideal SRAMs onto a single shared bus.

Parameters:
OUTSTANDING, 4, maximum accepted-but-unanswered transactions (power of 2, 2..16)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  instruction master request, held until inst_addr_ok
inst_wr  in  1  1 = write
inst_size  in  2  0/1/2 = byte/half/word
inst_addr  in  AW  request address
inst_wstrb  in  DW/8  byte write strobes
inst_wdata  in  DW  write data
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  response pulse
inst_rdata  out  DW  read data, valid with inst_data_ok
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  same widths as inst_*  data master request
data_addr_ok, data_data_ok, data_rdata  out  same widths as inst_*  data master handshake/response
mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  same widths  memory-side request
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response pulse, in request order
mem_rdata  in  DW  memory read data
err  out  1  sticky protocol error

Behaviour:
Protocol:
- A transfer handshakes when req & addr_ok are high in the same cycle.
- Masters hold all request fields stable until that handshake.
- Memory returns exactly one data_ok per accepted request, in acceptance order, at least 1 cycle after acceptance.
- Write responses carry no data.

Request path (combinational, 0-cycle):
- sel = lock_valid ? lock_id : (data_req ? DATA : INST).
- Data has fixed priority over inst.
- mem_req = ~rst & ~full & (lock_valid | data_req | inst_req).
- mem_wr/size/addr/wstrb/wdata are muxed from sel.
- x_addr_ok = mem_req & mem_addr_ok & (sel == x).
- The unselected master always sees addr_ok = 0.

Grant lock:
- Registers lock_valid (reset 0) and lock_id (reset INST).
- If mem_req & ~mem_addr_ok & ~lock_valid: lock_valid <= 1, lock_id <= sel.
- On mem_req & mem_addr_ok: lock_valid <= 0.
- While locked, sel never changes, even if a higher-priority data_req arrives. A request presented to memory is never withdrawn or swapped.

Owner FIFO:
- OUTSTANDING-deep, 1-bit entries, with a count register (reset 0).
- Push sel on mem_req & mem_addr_ok. Pop on mem_data_ok & ~empty.
- full = (count == OUTSTANDING).
- Full blocks new requests even when a pop occurs in the same cycle. Push/pop in the same cycle otherwise leaves count unchanged.
- Pointers wrap modulo OUTSTANDING.
- full cannot assert while locked, because count only rises on a handshake, which clears the lock.

Response path (combinational):
- inst_data_ok = mem_data_ok & ~empty & (head == INST).
- data_data_ok = mem_data_ok & ~empty & (head == DATA).
- inst_rdata and data_rdata are both driven with mem_rdata unconditionally.

Error:
- mem_data_ok while empty: no master pulse; err <= 1 from the next cycle until reset.

Reset:
- While rst is high: mem_req, both addr_ok and both data_ok are 0.
- Lock, FIFO and err are cleared.
- Reset mid-transaction discards all outstanding ownership. The memory side is reset by the same rst.

Decomposition:
- Package sram_like_pkg holds:
  - ID_INST = 1'b0, ID_DATA = 1'b1.
  - SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2.
  - Sram-like request field widths.
- One sub-module, owner_fifo: parameterised sync FIFO with push/pop/head/full/empty and count. The arbiter keeps the lock and muxing.

Test Plan:
1. Single inst read: inst_req addr 0x1C000000, mem_addr_ok=1 in cycle 0, mem_data_ok with rdata 0x02800C0C in cycle 2 -> inst_addr_ok in cycle 0, inst_data_ok + rdata 0x02800C0C in cycle 2, data_* silent.
2. Simultaneous requests: inst_req and data_req (write 0x8000 wdata 0xDEADBEEF wstrb 0xF) both in cycle 0, mem_addr_ok=1 -> data accepted in cycle 0, inst in cycle 1. Responses in cycles 3 and 4 route data_data_ok then inst_data_ok.
3. Lock: inst_req in cycle 0 with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays the inst address through cycle 3, inst accepted first, data accepted in cycle 4.
4. Full: 4 inst reads accepted with no mem_data_ok -> a 5th request sees mem_req=0. A pop-only cycle unblocks it the next cycle. FIFO wraps correctly over 10 transactions with alternating owners.
5. Spurious mem_data_ok with an empty FIFO -> no master data_ok, err=1 the next cycle and it stays set; rst clears it.
6. Reset with 3 outstanding -> count=0, lock_valid=0, mem_req=0 during rst. The first post-reset response routes correctly.
